// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / stall controller for a five-stage in-order core.
// A registered FSM (RUN, MEM_WAIT, HALT) tracks long stalls. All hold, flush
// and jump outputs are decoded combinationally from the current state and the
// hazard inputs, so the pipeline reacts in the same cycle.
// Priority within a cycle: system halt > memory wait > jump > load-use.
module pipe_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              sys_hold_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  input  logic              ld_use_i,
  input  logic              jump_req_i,
  input  logic [DATA_W-1:0] jump_addr_i,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              hold_id_ex_o,
  output logic              hold_ex_mem_o,
  output logic              hold_mem_wb_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              jump_ena_o,
  output logic [DATA_W-1:0] jump_addr_o,
  output logic [1:0]        state_o,
  output logic              bus_err_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int WAIT_W = 8;
  localparam int CNT_W  = 16;

  // The wait counter counts MEM_WAIT cycles starting from 0. The cycle whose
  // increment would bring it to 255 is the timeout cycle; together with the
  // RUN cycle that raised the request, exactly 255 cycles are held.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(254);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                bus_err_q, bus_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // Decode intents, before reset gating
  logic                hold_all;
  logic                ld_stall;
  logic                jump_take;
  logic                run_decode;
  logic                mem_check;
  logic                bus_err_set;

  // Saturating increment for the stall statistics counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Wrapping increment for the memory wait counter (bounded by the timeout)
  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
    return v + WAIT_W'(1);
  endfunction

  // Next-state and hazard decode
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_err_set = 1'b0;
    hold_all    = 1'b0;
    ld_stall    = 1'b0;
    jump_take   = 1'b0;
    run_decode  = 1'b0;
    mem_check   = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_decode = 1'b1;
        mem_check  = 1'b1;
      end

      ST_HALT: begin
        if (sys_hold_i) begin
          hold_all = 1'b1;
        end else begin
          // Release cycle behaves exactly like RUN
          run_decode = 1'b1;
          mem_check  = 1'b1;
          state_d    = ST_RUN;
        end
      end

      ST_MEM_WAIT: begin
        if (sys_hold_i) begin
          // Halt requests freeze the pipe but never abandon a memory access
          hold_all = 1'b1;
        end else if (mem_ack_i) begin
          // Access completes: release and honour jump / load-use this cycle
          run_decode = 1'b1;
          state_d    = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Memory never answered: flag it and let the pipe run on
          bus_err_set = 1'b1;
          wait_cnt_d  = wait_inc(wait_cnt_q);
          state_d     = ST_RUN;
        end else begin
          hold_all   = 1'b1;
          wait_cnt_d = wait_inc(wait_cnt_q);
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (run_decode) begin
      if ((state_q == ST_RUN) && sys_hold_i) begin
        hold_all = 1'b1;
        state_d  = ST_HALT;
      end else if (mem_check && mem_req_i && !mem_ack_i) begin
        hold_all   = 1'b1;
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = '0;
      end else if (jump_req_i) begin
        jump_take = 1'b1;
      end else if (ld_use_i) begin
        ld_stall = 1'b1;
      end
    end
  end

  // Outputs are forced inactive while reset is asserted
  assign hold_pc_o     = arst_n & (hold_all | ld_stall);
  assign hold_if_id_o  = arst_n & (hold_all | ld_stall);
  assign hold_id_ex_o  = arst_n & hold_all;
  assign hold_ex_mem_o = arst_n & hold_all;
  assign hold_mem_wb_o = arst_n & hold_all;
  assign flush_if_id_o = arst_n & jump_take;
  assign flush_id_ex_o = arst_n & (jump_take | ld_stall);
  assign jump_ena_o    = arst_n & jump_take;
  assign jump_addr_o   = jump_ena_o ? jump_addr_i : '0;

  assign bus_err_d   = bus_err_q | bus_err_set;
  assign stall_cnt_d = hold_pc_o ? sat_inc(stall_cnt_q) : stall_cnt_q;

  assign state_o     = state_q;
  assign bus_err_o   = bus_err_q;
  assign stall_cnt_o = stall_cnt_q;

  // State, wait counter, sticky error and stall statistics
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
